// File: rtl/softmax_normalizer_pkg.sv
// Shared widths and FSM encoding for the softmax normalizer; ALPHA_DATA_WIDTH is
// the alpha word width the aggregator and its alpha FIFO must agree on.
package softmax_normalizer_pkg;

   localparam int unsigned EXP_W            = 16;
   localparam int unsigned MAX_NODES        = 16;
   localparam int unsigned NODE_W           = $clog2(MAX_NODES + 1);
   localparam int unsigned SUM_W            = EXP_W + $clog2(MAX_NODES);
   localparam int unsigned ALPHA_F          = 15;
   localparam int unsigned ALPHA_W          = ALPHA_F + 1;
   localparam int unsigned ALPHA_DATA_WIDTH = ALPHA_W;
   localparam int unsigned IDX_W            = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DIVIDE, EMIT} softmax_state_t;

   // Index of the last neighbour after clamping the count into 1..MAX_NODES.
   function automatic logic [IDX_W-1:0] last_index(input logic [NODE_W-1:0] n);
      if (n == '0)
         return '0;
      if (n > NODE_W'(MAX_NODES))
         return IDX_W'(MAX_NODES - 1);
      return IDX_W'(n - NODE_W'(1));
   endfunction

endpackage

// File: rtl/softmax_normalizer_serial_divider.sv
// Restoring unsigned serial divider, one quotient bit per cycle; done pulses QW
// cycles after start. Requires (dividend >> QW) < divisor so the quotient fits QW bits.
module softmax_normalizer_serial_divider #(
   parameter int unsigned DVW = 31,
   parameter int unsigned DSW = 20,
   parameter int unsigned QW  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [DVW-1:0] dividend,
   input  logic [DSW-1:0] divisor,
   output logic           busy,
   output logic           done,
   output logic [QW-1:0]  quotient
);

   localparam int unsigned CNT_W = $clog2(QW + 1);

   logic [DSW-1:0]   rem;
   logic [DSW-1:0]   divisor_q;
   logic [QW-1:0]    quo;
   logic [CNT_W-1:0] cnt;
   logic [DSW:0]     shifted;
   logic             qbit;
   logic [DSW-1:0]   rem_next;

   // quo doubles as the remaining-dividend shift register and the quotient.
   always_comb begin
      shifted  = {rem, quo[QW-1]};
      qbit     = (shifted >= {1'b0, divisor_q});
      rem_next = qbit ? DSW'(shifted - {1'b0, divisor_q}) : shifted[DSW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem       <= '0;
         divisor_q <= '0;
         quo       <= '0;
         cnt       <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && cnt == '0) begin
            rem       <= DSW'(dividend >> QW);
            quo       <= dividend[QW-1:0];
            divisor_q <= divisor;
            cnt       <= CNT_W'(QW);
         end else if (cnt != '0) begin
            rem <= rem_next;
            quo <= {quo[QW-2:0], qbit};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
               done <= 1'b1;
         end
      end
   end

   assign busy     = (cnt != '0);
   assign quotient = quo;

endmodule

// File: rtl/softmax_normalizer.sv
// Buffers one neighbourhood of exp scores, sums them, and writes alpha = e*2^ALPHA_F/sum
// per score in arrival order. Define SOFTMAX_STALL_CNT_EN to add the stall_cnt_o counter.
module softmax_normalizer
   import softmax_normalizer_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               coef_valid_i,
   output logic               coef_ready_o,
   input  logic [EXP_W-1:0]   coef_data_i,
   input  logic [NODE_W-1:0]  coef_num_nodes_i,
   output logic [ALPHA_W-1:0] alpha_FIFO_din,
   output logic               alpha_FIFO_wr_vld,
   input  logic               alpha_FIFO_full,
   output logic               node_done_o
`ifdef SOFTMAX_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt_o
`endif
);

   softmax_state_t     state;
   logic [EXP_W-1:0]   buffer [MAX_NODES];
   logic [IDX_W-1:0]   last_idx;
   logic [IDX_W-1:0]   in_idx;
   logic [IDX_W-1:0]   out_idx;
   logic [SUM_W-1:0]   sum;
   logic               xfer;
   logic               div_start;
   logic               div_busy;
   logic               div_done;
   logic [ALPHA_W-1:0] div_quotient;

   assign xfer              = coef_valid_i && coef_ready_o;
   assign div_start         = (state == DIVIDE) && !div_busy && !div_done && (sum != '0);
   assign alpha_FIFO_wr_vld = (state == EMIT) && !alpha_FIFO_full;
   assign node_done_o       = alpha_FIFO_wr_vld && (out_idx == last_idx);

   always_ff @(posedge clk) begin
      if (xfer)
         buffer[(state == IDLE) ? '0 : in_idx] <= coef_data_i;
   end

   softmax_normalizer_serial_divider #(
      .DVW (EXP_W + ALPHA_F),
      .DSW (SUM_W),
      .QW  (ALPHA_W)
   ) u_divider (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .dividend ({buffer[out_idx], {ALPHA_F{1'b0}}}),
      .divisor  (sum),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quotient)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         coef_ready_o   <= 1'b1;
         last_idx       <= '0;
         in_idx         <= '0;
         out_idx        <= '0;
         sum            <= '0;
         alpha_FIFO_din <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  last_idx <= last_index(coef_num_nodes_i);
                  sum      <= SUM_W'(coef_data_i);
                  in_idx   <= IDX_W'(1);
                  out_idx  <= '0;
                  if (last_index(coef_num_nodes_i) == '0) begin
                     state        <= DIVIDE;
                     coef_ready_o <= 1'b0;
                  end else begin
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (xfer) begin
                  sum    <= sum + SUM_W'(coef_data_i);
                  in_idx <= in_idx + IDX_W'(1);
                  if (in_idx == last_idx) begin
                     state        <= DIVIDE;
                     coef_ready_o <= 1'b0;
                  end
               end
            end
            DIVIDE: begin
               // An all-zero neighbourhood bypasses the divider entirely.
               if (sum == '0) begin
                  alpha_FIFO_din <= '0;
                  state          <= EMIT;
               end else if (div_done) begin
                  alpha_FIFO_din <= div_quotient;
                  state          <= EMIT;
               end
            end
            EMIT: begin
               if (!alpha_FIFO_full) begin
                  out_idx <= out_idx + IDX_W'(1);
                  if (out_idx == last_idx) begin
                     state        <= IDLE;
                     coef_ready_o <= 1'b1;
                  end else begin
                     state <= DIVIDE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SOFTMAX_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt_o <= '0;
      else if (state == EMIT && alpha_FIFO_full && stall_cnt_o != '1)
         stall_cnt_o <= stall_cnt_o + 32'd1;
   end
`endif

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed bench for softmax_normalizer; expected alphas are hand-computed floor(e*32768/sum).
// Build with +define+SOFTMAX_STALL_CNT_EN to also check the stall counter.
module tb_softmax_normalizer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        coef_valid = 1'b0;
   logic        coef_ready;
   logic [15:0] coef_data = '0;
   logic [4:0]  coef_num = '0;
   logic [15:0] alpha_din;
   logic        alpha_wr_vld;
   logic        alpha_full = 1'b0;
   logic        node_done;
`ifdef SOFTMAX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int viol = 0;

   typedef struct {
      logic [15:0] din;
      logic        done;
      int          cyc;
   } wr_t;
   wr_t wlog [$];

   softmax_normalizer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .coef_valid_i     (coef_valid),
      .coef_ready_o     (coef_ready),
      .coef_data_i      (coef_data),
      .coef_num_nodes_i (coef_num),
      .alpha_FIFO_din   (alpha_din),
      .alpha_FIFO_wr_vld(alpha_wr_vld),
      .alpha_FIFO_full  (alpha_full),
      .node_done_o      (node_done)
`ifdef SOFTMAX_STALL_CNT_EN
      ,
      .stall_cnt_o      (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Write monitor, sampling 1 time unit before each rising edge.
   always begin
      wr_t w;
      @(negedge clk);
      #4;
      cyc++;
      if (alpha_wr_vld === 1'b1) begin
         w.din  = alpha_din;
         w.done = node_done;
         w.cyc  = cyc;
         wlog.push_back(w);
         if (alpha_full !== 1'b0)
            viol++;
      end else if (node_done === 1'b1) begin
         viol++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_node(input logic [4:0] n, input logic [15:0] vals [$], output bit ok);
      int unsigned t;
      ok = 1'b1;
      foreach (vals[i]) begin
         t = 0;
         while (coef_ready !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
         end
         if (t >= 400)
            ok = 1'b0;
         coef_valid = 1'b1;
         coef_data  = vals[i];
         coef_num   = (i == 0) ? n : 5'd0;
         @(negedge clk);
      end
      coef_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n, output bit ok);
      int t = 0;
      while (wlog.size() < n && t < 60 * n + 40) begin
         @(negedge clk);
         t++;
      end
      ok = (wlog.size() >= n);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      compared++;
      if (coef_ready !== 1'b1 || alpha_wr_vld !== 1'b0 || node_done !== 1'b0 || alpha_din !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_outputs: ready=%b wr_vld=%b done=%b din=%0d, want 1 0 0 0",
                  coef_ready, alpha_wr_vld, node_done, alpha_din);
      end
`ifdef SOFTMAX_STALL_CNT_EN
      compared++;
      if (stall_cnt !== 32'd0) begin
         mismatched++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (coef_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_release_ready: got %b want 1", coef_ready);
      end
   endtask

   task automatic test_single();
      logic [15:0] v [$];
      bit ok, okw;
      v = '{16'd5};
      wlog.delete();
      send_node(5'd1, v, ok);
      wait_writes(1, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 1) begin
         mismatched++;
         $display("FAIL single_count: got %0d writes want 1", wlog.size());
      end
      compared++;
      if (wlog.size() < 1 || wlog[0].din !== 16'd32768 || wlog[0].done !== 1'b1) begin
         mismatched++;
         $display("FAIL single_alpha: got din=%0d done=%b want 32768 1",
                  (wlog.size() > 0) ? wlog[0].din : 16'hx, (wlog.size() > 0) ? wlog[0].done : 1'bx);
      end
   endtask

   task automatic test_clamp_zero();
      logic [15:0] v [$];
      bit ok, okw;
      v = '{16'd9};
      wlog.delete();
      send_node(5'd0, v, ok);
      wait_writes(1, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 1 || wlog[0].din !== 16'd32768 || wlog[0].done !== 1'b1) begin
         mismatched++;
         $display("FAIL clamp_zero: got %0d writes, want one write of 32768 with done", wlog.size());
      end
   endtask

   task automatic test_pair();
      logic [15:0] v [$];
      bit ok, okw;
      v = '{16'd1, 16'd1};
      wlog.delete();
      send_node(5'd2, v, ok);
      wait_writes(2, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 2) begin
         mismatched++;
         $display("FAIL pair_count: got %0d writes want 2", wlog.size());
      end
      for (int i = 0; i < 2; i++) begin
         compared++;
         if (wlog.size() <= i || wlog[i].din !== 16'd16384 || wlog[i].done !== (i == 1)) begin
            mismatched++;
            $display("FAIL pair_alpha[%0d]: got din=%0d done=%b want 16384 %b", i,
                     (wlog.size() > i) ? wlog[i].din : 16'hx, (wlog.size() > i) ? wlog[i].done : 1'bx, i == 1);
         end
      end
   endtask

   task automatic test_four();
      logic [15:0] v [$];
      logic [15:0] exp_a [4];
      bit ok, okw;
      v = '{16'd1, 16'd2, 16'd3, 16'd4};
      exp_a = '{16'd3276, 16'd6553, 16'd9830, 16'd13107};
      wlog.delete();
      send_node(5'd4, v, ok);
      compared++;
      if (coef_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL four_ready_in_divide: got %b want 0", coef_ready);
      end
      wait_writes(4, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 4) begin
         mismatched++;
         $display("FAIL four_count: got %0d writes want 4", wlog.size());
      end
      foreach (exp_a[i]) begin
         compared++;
         if (wlog.size() <= i || wlog[i].din !== exp_a[i] || wlog[i].done !== (i == 3)) begin
            mismatched++;
            $display("FAIL four_alpha[%0d]: got din=%0d done=%b want %0d %b", i,
                     (wlog.size() > i) ? wlog[i].din : 16'hx, (wlog.size() > i) ? wlog[i].done : 1'bx,
                     exp_a[i], i == 3);
         end
      end
   endtask

   task automatic test_zero_back_to_back();
      logic [15:0] v1 [$];
      logic [15:0] v2 [$];
      logic [15:0] exp_a [5];
      logic        exp_d [5];
      bit ok1, ok2, okw;
      v1 = '{16'd0, 16'd0, 16'd0};
      v2 = '{16'd3, 16'd1};
      exp_a = '{16'd0, 16'd0, 16'd0, 16'd24576, 16'd8192};
      exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      wlog.delete();
      send_node(5'd3, v1, ok1);
      send_node(5'd2, v2, ok2);
      wait_writes(5, okw);
      compared++;
      if (!ok1 || !ok2 || !okw || wlog.size() != 5) begin
         mismatched++;
         $display("FAIL zero_b2b_count: got %0d writes want 5", wlog.size());
      end
      foreach (exp_a[i]) begin
         compared++;
         if (wlog.size() <= i || wlog[i].din !== exp_a[i] || wlog[i].done !== exp_d[i]) begin
            mismatched++;
            $display("FAIL zero_b2b_alpha[%0d]: got din=%0d done=%b want %0d %b", i,
                     (wlog.size() > i) ? wlog[i].din : 16'hx, (wlog.size() > i) ? wlog[i].done : 1'bx,
                     exp_a[i], exp_d[i]);
         end
      end
      // Zero sum skips the divider: one DIVIDE plus one EMIT cycle per element.
      compared++;
      if (wlog.size() < 3 || wlog[2].cyc - wlog[0].cyc != 4) begin
         mismatched++;
         $display("FAIL zero_no_divider: got spacing %0d cycles want 4",
                  (wlog.size() >= 3) ? wlog[2].cyc - wlog[0].cyc : -1);
      end
   endtask

   task automatic test_clamp_max();
      logic [15:0] v [$];
      bit ok, okw;
      int bad = 0;
      for (int i = 0; i < 16; i++)
         v.push_back(16'd1);
      wlog.delete();
      send_node(5'd31, v, ok);
      wait_writes(16, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 16) begin
         mismatched++;
         $display("FAIL clamp_max_count: got %0d writes want 16", wlog.size());
      end
      foreach (wlog[i])
         if (wlog[i].din !== 16'd2048 || wlog[i].done !== (i == 15))
            bad++;
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("FAIL clamp_max_alpha: got %0d bad writes want 0 (each 2048, done on last)", bad);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] v [$];
      bit ok, okw, found;
      int t, bad_vld, bad_din;
      v = '{16'd3, 16'd1};
      wlog.delete();
      send_node(5'd2, v, ok);
      found = 1'b0;
      t = 0;
      while (!found && t < 100) begin
         @(negedge clk);
         #1;
         if (alpha_wr_vld === 1'b1)
            found = 1'b1;
         else
            t++;
      end
      alpha_full = 1'b1;
      compared++;
      if (!ok || !found) begin
         mismatched++;
         $display("FAIL stall_reach_emit: got found=%b want 1", found);
      end
      bad_vld = 0;
      bad_din = 0;
      repeat (20) begin
         @(negedge clk);
         #1;
         if (alpha_wr_vld !== 1'b0)
            bad_vld++;
         if (alpha_din !== 16'd24576)
            bad_din++;
      end
      alpha_full = 1'b0;
      compared++;
      if (bad_vld != 0) begin
         mismatched++;
         $display("FAIL stall_no_write: got %0d cycles with wr_vld while full want 0", bad_vld);
      end
      compared++;
      if (bad_din != 0) begin
         mismatched++;
         $display("FAIL stall_din_hold: got %0d cycles with din != 24576 want 0", bad_din);
      end
      #3;
      compared++;
      if (alpha_wr_vld !== 1'b1 || alpha_din !== 16'd24576) begin
         mismatched++;
         $display("FAIL stall_release_write: got wr_vld=%b din=%0d want 1 24576", alpha_wr_vld, alpha_din);
      end
      wait_writes(2, okw);
      compared++;
      if (!okw || wlog.size() != 2 || wlog[0].din !== 16'd24576 || wlog[1].din !== 16'd8192 ||
          wlog[0].done !== 1'b0 || wlog[1].done !== 1'b1) begin
         mismatched++;
         $display("FAIL stall_sequence: got %0d writes want 24576 then 8192 with done", wlog.size());
      end
`ifdef SOFTMAX_STALL_CNT_EN
      compared++;
      if (stall_cnt !== 32'd20) begin
         mismatched++;
         $display("FAIL stall_cnt: got %0d want 20", stall_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid_divide();
      logic [15:0] v [$];
      bit ok, okw;
      v = '{16'd1, 16'd2, 16'd3, 16'd4};
      wlog.delete();
      send_node(5'd4, v, ok);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compared++;
      if (coef_ready !== 1'b1 || alpha_wr_vld !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset_ready: got ready=%b wr_vld=%b want 1 0", coef_ready, alpha_wr_vld);
      end
`ifdef SOFTMAX_STALL_CNT_EN
      compared++;
      if (stall_cnt !== 32'd0) begin
         mismatched++;
         $display("FAIL mid_reset_stall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      repeat (60) @(negedge clk);
      compared++;
      if (wlog.size() != 0) begin
         mismatched++;
         $display("FAIL mid_reset_no_write: got %0d writes want 0", wlog.size());
      end
      v = '{16'd1, 16'd1};
      send_node(5'd2, v, ok);
      wait_writes(2, okw);
      compared++;
      if (!ok || !okw || wlog.size() != 2 || wlog[0].din !== 16'd16384 || wlog[1].din !== 16'd16384 ||
          wlog[1].done !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_reset_fresh_node: got %0d writes want 16384 16384 with done", wlog.size());
      end
      compared++;
      if (viol != 0) begin
         mismatched++;
         $display("FAIL protocol: got %0d write-while-full or stray done events want 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_clamp_zero();
      test_pair();
      test_four();
      test_zero_back_to_back();
      test_clamp_max();
      test_backpressure();
      test_reset_mid_divide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
